// File: rtl/mux.sv
// Byte-to-word packer: collects four bytes from the decryptor picked by select into one word behind a valid/ready output register.
// Optional feature macro MUX_ERR_CNT_EN adds err_cnt_o, a saturating count of drop_o pulses.
module mux #(
    parameter int MST_DWIDTH = 32,
    parameter int SYS_DWIDTH = 8
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic [1:0]            select,
    input  logic [SYS_DWIDTH-1:0] data0_i,
    input  logic                  valid0_i,
    input  logic [SYS_DWIDTH-1:0] data1_i,
    input  logic                  valid1_i,
    input  logic [SYS_DWIDTH-1:0] data2_i,
    input  logic                  valid2_i,
    output logic [MST_DWIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  drop_o
`ifdef MUX_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt_o
`endif
);

    localparam int LANES = MST_DWIDTH / SYS_DWIDTH;
    localparam int CNT_W = $clog2(LANES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LANES);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [MST_DWIDTH-1:0]   pack_q, pack_d;
    logic [MST_DWIDTH-1:0]   data_d;
    logic                    valid_d;
    logic                    drop_d;
    logic [1:0]              sel_q;
    logic [SYS_DWIDTH-1:0]   byte_in;
    logic                    accept;
    logic                    sel_change;
    logic                    out_free;
    logic                    transfer;

    assign sel_change = (select != sel_q);
    assign out_free   = !valid_o || ready_i;

    always_comb begin
        byte_in = '0;
        accept  = 1'b0;
        case (select)
            2'd0: begin
                byte_in = data0_i;
                accept  = valid0_i;
            end
            2'd1: begin
                byte_in = data1_i;
                accept  = valid1_i;
            end
            2'd2: begin
                byte_in = data2_i;
                accept  = valid2_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst_n) begin
        if (rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            pack_q  <= '0;
            sel_q   <= 2'd0;
            data_o  <= '0;
            valid_o <= 1'b0;
            drop_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pack_q  <= pack_d;
            sel_q   <= select;
            data_o  <= data_d;
            valid_o <= valid_d;
            drop_o  <= drop_d;
        end
    end

    // A select change abandons a partial word; the new channel's byte restarts at lane 0.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pack_d   = pack_q;
        drop_d   = 1'b0;
        transfer = 1'b0;
        case (state_q)
            FILL: begin
                if (sel_change && cnt_q != '0) begin
                    drop_d = 1'b1;
                    if (accept) begin
                        pack_d[SYS_DWIDTH-1:0] = byte_in;
                        cnt_d = CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end else if (accept) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            pack_d[k*SYS_DWIDTH +: SYS_DWIDTH] = byte_in;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_FULL) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_free) begin
                    transfer = 1'b1;
                    state_d  = FILL;
                    if (accept) begin
                        pack_d[SYS_DWIDTH-1:0] = byte_in;
                        cnt_d = CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end else if (accept) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy_o  = (cnt_q != '0);
        valid_d = valid_o;
        data_d  = data_o;
        if (transfer) begin
            valid_d = 1'b1;
            data_d  = pack_q;
        end else if (valid_o && ready_i) begin
            valid_d = 1'b0;
        end
    end

`ifdef MUX_ERR_CNT_EN
    always_ff @(posedge clk_sys or posedge rst_n) begin
        if (rst_n) begin
            err_cnt_o <= 8'd0;
        end else if (drop_d && err_cnt_o != 8'hFF) begin
            err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux.sv
// Self-checking bench for mux: scenario tasks drive bytes, push expected words to a scoreboard,
// and compare against words captured from valid/ready handshakes.
module tb_mux;

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  select = 2'd0;
    logic [7:0]  data0_i = 8'd0;
    logic        valid0_i = 1'b0;
    logic [7:0]  data1_i = 8'd0;
    logic        valid1_i = 1'b0;
    logic [7:0]  data2_i = 8'd0;
    logic        valid2_i = 1'b0;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        busy_o;
    logic        drop_o;
`ifdef MUX_ERR_CNT_EN
    logic [7:0]  err_cnt_o;
`endif

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          drop_count = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    mux dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .select   (select),
        .data0_i  (data0_i),
        .valid0_i (valid0_i),
        .data1_i  (data1_i),
        .valid1_i (valid1_i),
        .data2_i  (data2_i),
        .valid2_i (valid2_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .busy_o   (busy_o),
        .drop_o   (drop_o)
`ifdef MUX_ERR_CNT_EN
        ,
        .err_cnt_o(err_cnt_o)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    // Words are captured where a handshake will complete at the next rising edge.
    always @(negedge clk_sys) begin
        if (rst_n == 1'b0) begin
            if (valid_o && ready_i) got_q.push_back(data_o);
            if (drop_o) drop_count++;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic [1:0] ch, input logic [7:0] b);
        case (ch)
            2'd0: begin data0_i = b; valid0_i = 1'b1; end
            2'd1: begin data1_i = b; valid1_i = 1'b1; end
            2'd2: begin data2_i = b; valid2_i = 1'b1; end
            default: ;
        endcase
        tick();
        valid0_i = 1'b0;
        valid1_i = 1'b0;
        valid2_i = 1'b0;
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 40 && got_q.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) tick();
        total_cnt += 4;
        if (data_o !== 32'h0) $display("[TB] FAIL reset_data: got %h expected %h", data_o, 32'h0); else pass_cnt++;
        if (valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); else pass_cnt++;
        if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); else pass_cnt++;
        if (drop_o !== 1'b0) $display("[TB] FAIL reset_drop: got %b expected 0", drop_o); else pass_cnt++;
        rst_n = 1'b0;
        tick();
    endtask

    task automatic test_basic_pack();
        logic [31:0] exp_w, got_w;
        int drops0;
        drops0 = drop_count;
        select = 2'd0;
        ready_i = 1'b1;
        exp_q.push_back(32'h44332211);
        send(2'd0, 8'h11);
        total_cnt++;
        if (busy_o !== 1'b1) $display("[TB] FAIL basic_busy: got %b expected 1", busy_o); else pass_cnt++;
        send(2'd0, 8'h22);
        send(2'd0, 8'h33);
        send(2'd0, 8'h44);
        total_cnt++;
        if (valid_o !== 1'b0) $display("[TB] FAIL basic_latency: got valid %b expected 0", valid_o); else pass_cnt++;
        tick();
        total_cnt += 3;
        if (valid_o !== 1'b1) $display("[TB] FAIL basic_valid: got %b expected 1", valid_o); else pass_cnt++;
        if (data_o !== 32'h44332211) $display("[TB] FAIL basic_data: got %h expected %h", data_o, 32'h44332211); else pass_cnt++;
        if (busy_o !== 1'b0) $display("[TB] FAIL basic_busy_clear: got %b expected 0", busy_o); else pass_cnt++;
        tick();
        total_cnt++;
        if (valid_o !== 1'b0) $display("[TB] FAIL basic_valid_pulse: got %b expected 0", valid_o); else pass_cnt++;
        wait_words(1);
        total_cnt++;
        if (got_q.size() !== 1) $display("[TB] FAIL basic_count: got %0d expected 1", got_q.size()); else pass_cnt++;
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            got_w = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
            total_cnt++;
            if (got_w !== exp_w) $display("[TB] FAIL basic_word: got %h expected %h", got_w, exp_w); else pass_cnt++;
        end
        total_cnt++;
        if (drop_count !== drops0) $display("[TB] FAIL basic_drops: got %0d expected %0d", drop_count, drops0); else pass_cnt++;
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w, got_w;
        logic [7:0]  b;
        int drops0;
        drops0 = drop_count;
        select = 2'd1;
        ready_i = 1'b1;
        for (int w = 0; w < 3; w++) begin
            exp_w = 32'h0;
            for (int i = 0; i < 4; i++) begin
                b = 8'($urandom_range(0, 255));
                exp_w[8*i +: 8] = b;
                if (i == 3) exp_q.push_back(exp_w);
                send(2'd1, b);
            end
        end
        total_cnt++;
        if (got_q.size() !== 2) $display("[TB] FAIL b2b_throughput: got %0d words expected 2", got_q.size()); else pass_cnt++;
        wait_words(3);
        total_cnt++;
        if (got_q.size() !== 3) $display("[TB] FAIL b2b_count: got %0d expected 3", got_q.size()); else pass_cnt++;
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            got_w = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
            total_cnt++;
            if (got_w !== exp_w) $display("[TB] FAIL b2b_word: got %h expected %h", got_w, exp_w); else pass_cnt++;
        end
        total_cnt++;
        if (drop_count !== drops0) $display("[TB] FAIL b2b_drops: got %0d expected %0d", drop_count, drops0); else pass_cnt++;
        got_q.delete();
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w, got_w;
        int drops0;
        drops0 = drop_count;
        select = 2'd1;
        ready_i = 1'b0;
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        for (int i = 1; i <= 8; i++) send(2'd1, 8'(i));
        total_cnt += 3;
        if (valid_o !== 1'b1) $display("[TB] FAIL bp_valid: got %b expected 1", valid_o); else pass_cnt++;
        if (data_o !== 32'h04030201) $display("[TB] FAIL bp_hold: got %h expected %h", data_o, 32'h04030201); else pass_cnt++;
        if (busy_o !== 1'b1) $display("[TB] FAIL bp_busy: got %b expected 1", busy_o); else pass_cnt++;
        send(2'd1, 8'h09);
        total_cnt += 2;
        if (drop_o !== 1'b1) $display("[TB] FAIL bp_drop: got %b expected 1", drop_o); else pass_cnt++;
        if (data_o !== 32'h04030201) $display("[TB] FAIL bp_hold2: got %h expected %h", data_o, 32'h04030201); else pass_cnt++;
        tick();
        total_cnt++;
        if (drop_o !== 1'b0) $display("[TB] FAIL bp_drop_pulse: got %b expected 0", drop_o); else pass_cnt++;
        ready_i = 1'b1;
        tick();
        total_cnt += 2;
        if (valid_o !== 1'b1) $display("[TB] FAIL bp_next_valid: got %b expected 1", valid_o); else pass_cnt++;
        if (data_o !== 32'h08070605) $display("[TB] FAIL bp_next_data: got %h expected %h", data_o, 32'h08070605); else pass_cnt++;
        wait_words(2);
        total_cnt++;
        if (got_q.size() !== 2) $display("[TB] FAIL bp_count: got %0d expected 2", got_q.size()); else pass_cnt++;
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            got_w = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
            total_cnt++;
            if (got_w !== exp_w) $display("[TB] FAIL bp_word: got %h expected %h", got_w, exp_w); else pass_cnt++;
        end
        total_cnt++;
        if (drop_count !== drops0 + 1) $display("[TB] FAIL bp_drops: got %0d expected %0d", drop_count, drops0 + 1); else pass_cnt++;
        got_q.delete();
        tick();
    endtask

    task automatic test_select_change();
        logic [31:0] exp_w, got_w;
        int drops0;
        drops0 = drop_count;
        ready_i = 1'b1;
        select = 2'd2;
        send(2'd2, 8'hAA);
        send(2'd2, 8'hBB);
        select = 2'd0;
        exp_q.push_back(32'h04030201);
        send(2'd0, 8'h01);
        total_cnt += 2;
        if (drop_o !== 1'b1) $display("[TB] FAIL sel_drop: got %b expected 1", drop_o); else pass_cnt++;
        if (busy_o !== 1'b1) $display("[TB] FAIL sel_busy: got %b expected 1", busy_o); else pass_cnt++;
        send(2'd0, 8'h02);
        send(2'd0, 8'h03);
        send(2'd0, 8'h04);
        wait_words(1);
        total_cnt++;
        if (got_q.size() !== 1) $display("[TB] FAIL sel_count: got %0d expected 1", got_q.size()); else pass_cnt++;
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            got_w = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
            total_cnt++;
            if (got_w !== exp_w) $display("[TB] FAIL sel_word: got %h expected %h", got_w, exp_w); else pass_cnt++;
        end
        total_cnt++;
        if (drop_count !== drops0 + 1) $display("[TB] FAIL sel_drops: got %0d expected %0d", drop_count, drops0 + 1); else pass_cnt++;
        got_q.delete();
        tick();
    endtask

    task automatic test_ignored();
        select = 2'd3;
        data0_i = 8'h5A;
        data1_i = 8'hA5;
        data2_i = 8'h3C;
        valid0_i = 1'b1;
        valid1_i = 1'b1;
        valid2_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total_cnt += 2;
            if (busy_o !== 1'b0) $display("[TB] FAIL ign_busy: got %b expected 0", busy_o); else pass_cnt++;
            if (valid_o !== 1'b0) $display("[TB] FAIL ign_valid: got %b expected 0", valid_o); else pass_cnt++;
        end
        valid0_i = 1'b0;
        valid1_i = 1'b0;
        valid2_i = 1'b0;
    endtask

    task automatic test_midword_reset();
        logic [31:0] exp_w, got_w;
        int drops0;
        select = 2'd0;
        ready_i = 1'b1;
        send(2'd0, 8'h5A);
        send(2'd0, 8'h6B);
        send(2'd0, 8'h7C);
        total_cnt++;
        if (busy_o !== 1'b1) $display("[TB] FAIL mr_busy_pre: got %b expected 1", busy_o); else pass_cnt++;
        drops0 = drop_count;
        rst_n = 1'b1;
        #1;
        total_cnt += 4;
        if (data_o !== 32'h0) $display("[TB] FAIL mr_data: got %h expected %h", data_o, 32'h0); else pass_cnt++;
        if (valid_o !== 1'b0) $display("[TB] FAIL mr_valid: got %b expected 0", valid_o); else pass_cnt++;
        if (busy_o !== 1'b0) $display("[TB] FAIL mr_busy: got %b expected 0", busy_o); else pass_cnt++;
        if (drop_o !== 1'b0) $display("[TB] FAIL mr_drop: got %b expected 0", drop_o); else pass_cnt++;
        tick();
        rst_n = 1'b0;
        exp_q.push_back(32'hC4C3C2C1);
        send(2'd0, 8'hC1);
        send(2'd0, 8'hC2);
        send(2'd0, 8'hC3);
        send(2'd0, 8'hC4);
        wait_words(1);
        total_cnt++;
        if (got_q.size() !== 1) $display("[TB] FAIL mr_count: got %0d expected 1", got_q.size()); else pass_cnt++;
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            got_w = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
            total_cnt++;
            if (got_w !== exp_w) $display("[TB] FAIL mr_word: got %h expected %h", got_w, exp_w); else pass_cnt++;
        end
        total_cnt++;
        if (drop_count !== drops0) $display("[TB] FAIL mr_drops: got %0d expected %0d", drop_count, drops0); else pass_cnt++;
        got_q.delete();
        tick();
    endtask

`ifdef MUX_ERR_CNT_EN
    task automatic test_err_cnt();
        int drops0;
        drops0 = drop_count;
        select = 2'd0;
        ready_i = 1'b0;
        for (int i = 0; i < 308; i++) send(2'd0, 8'(i));
        tick();
        total_cnt += 2;
        if (drop_count !== drops0 + 300) $display("[TB] FAIL err_drops: got %0d expected %0d", drop_count, drops0 + 300); else pass_cnt++;
        if (err_cnt_o !== 8'hFF) $display("[TB] FAIL err_cnt_sat: got %0d expected 255", err_cnt_o); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (err_cnt_o !== 8'h00) $display("[TB] FAIL err_cnt_reset: got %0d expected 0", err_cnt_o); else pass_cnt++;
        tick();
        rst_n = 1'b0;
        got_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_pack();
        test_back_to_back();
        test_backpressure();
        test_select_change();
        test_ignored();
        test_midword_reset();
`ifdef MUX_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/mux.md
# mux

Byte-to-word packer on the decryption output path, the inverse of the input demux. It takes the 8-bit plaintext stream from the decryptor chosen by `select` (Caesar, Scytale or ZigZag) and assembles four consecutive bytes into one 32-bit word. Each word is presented through a valid/ready output register. The block runs in the system clock domain.

## Interface
Parameters:
- `MST_DWIDTH`, default 32: output word width.
- `SYS_DWIDTH`, default 8: byte width. `MST_DWIDTH / SYS_DWIDTH` = 4 lanes (LANES).

Ports:
- `clk_sys`  in  1: the single clock. All state updates on its rising edge.
- `rst_n`  in  1: reset, **asynchronous, active-high**. Logic is in reset while `rst_n` = 1.
- `select`  in  2: 0 = Caesar, 1 = Scytale, 2 = ZigZag, 3 = no source.
- `data0_i`  in  SYS_DWIDTH, `valid0_i`  in  1: Caesar decryptor byte and its valid.
- `data1_i`  in  SYS_DWIDTH, `valid1_i`  in  1: Scytale decryptor byte and its valid.
- `data2_i`  in  SYS_DWIDTH, `valid2_i`  in  1: ZigZag decryptor byte and its valid.
- `data_o`  out  MST_DWIDTH: packed word.
- `valid_o`  out  1: `data_o` holds a word.
- `ready_i`  in  1: consumer accepts the word when `valid_o` and `ready_i` are both 1.
- `busy_o`  out  1: the packer holds at least one byte.
- `drop_o`  out  1: one-cycle pulse when bytes are discarded.

## Operation
- **Byte acceptance:** a byte is accepted when the valid of the channel chosen by `select` is 1. Valids of non-selected channels are ignored. With `select` = 3, no byte is accepted.
- **Lane order:** the accepted byte k (k = 0..3) is written to `pack[8*k +: 8]`, so the first byte lands in the LSB lane. A 3-bit lane counter `cnt` (0..4) tracks the fill.
- **State FILL (`cnt` < 4):** each accepted byte increments `cnt`. When the 4th byte is accepted, the state becomes HOLD.
- **State HOLD (`cnt` = 4):** `pack` transfers to `data_o` and `valid_o` is set on the first edge where the output register is free. The register is free when `valid_o` = 0, or when `valid_o` and `ready_i` are both 1 at that edge.
  - On transfer, `cnt` goes to 0. A byte accepted on that same edge is written to lane 0 and `cnt` becomes 1.
  - If a byte is accepted while in HOLD and no transfer happens, the byte is dropped and `drop_o` pulses.
- **Select change:** `select` is registered as `sel_q`. At an edge where `select` ≠ `sel_q` and state is FILL with `cnt` in 1..3:
  - the partial word is discarded and `drop_o` pulses;
  - a byte accepted that cycle from the new channel goes to lane 0 (`cnt` = 1), otherwise `cnt` = 0.
  - A select change in HOLD does not affect the completed word.
- **Output hold:** `data_o` is stable while `valid_o` = 1 and `ready_i` = 0. `valid_o` clears on handshake unless a new word transfers on the same edge.
- **`busy_o`:** equals (`cnt` ≠ 0).

## Timing
- Reset values: `data_o` = 0, `valid_o` = 0, `busy_o` = 0, `drop_o` = 0, `cnt` = 0, `pack` = 0, `sel_q` = 0, err counter = 0.
- Latency: 4th byte accepted at edge N with the output free → `valid_o` = 1 after edge N+1 (HOLD → transfer).
- Throughput: sustained 1 byte/cycle with `ready_i` held at 1, i.e. one word every 4 cycles, no bubbles.
- Reset asserted mid-word or with `valid_o` = 1: everything clears immediately, and the pending word is lost without a `drop_o` pulse.
- First edge after reset release: bytes are accepted normally. `sel_q` = 0, so a nonzero `select` with `cnt` = 0 causes no drop.

## Configuration
- `MUX_ERR_CNT_EN`
  - Defined: adds output port `err_cnt_o` (8 bits). It increments once per `drop_o` pulse, saturates at 255, and resets to 0.
  - Undefined: the port and the counter are absent. `drop_o` behaviour is unchanged.

## Test plan
- **Basic pack:** reset then release; `select` = 0; bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `ready_i` = 1 → `data_o` = 0x44332211, `valid_o` high for one cycle, `drop_o` never pulses.
- **Backpressure:** `select` = 1, `ready_i` = 0, eight bytes 0x01..0x08 → word 0x04030201 held; after the 4th byte of the second word, further bytes drop. Raise `ready_i` → 0x04030201 handshakes, then 0x08070605 follows on the next edge.
- **Select change:** `select` = 2, two bytes 0xAA, 0xBB, then `select` = 0 with bytes 0x01..0x04 → `drop_o` pulses once, output = 0x04030201.
- **Ignored channels:** `select` = 3 with all three valids active for 10 cycles → `busy_o` stays 0, `valid_o` stays 0.
- **Mid-word reset:** reset asserted after 3 bytes → all outputs 0 immediately; after release, a fresh 4 bytes produce the correct word.
- **Error counter (`MUX_ERR_CNT_EN`):** force 300 drops → `err_cnt_o` = 255.
